pixel_readout_receiver: RTL and testbench

Host-side receiver for the pixel array's read-out bus. On a start request it issues one READ_RESET pulse, then a series of READ_CLK pulses. After each pulse it captures one parallel bus word of OUTPUT_BUS_PIXEL_WIDTH pixels and unpacks the word into a single-pixel valid/ready stream. It sits between the pixel array's DATA_OUT/READ_CLK_IN/READ_RESET ports and the downstream frame sink.

---
 rtl/pixel_readout_receiver.sv | 166 ++++++++++++++++
 tb/tb_pixel_readout_receiver.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_receiver.sv
// Host-side receiver for the pixel array read-out bus: issues READ_RESET/READ_CLK, captures bus words, streams pixels.
// Optional macro PIXEL_READOUT_GRAY_DECODE_EN converts each captured Gray-coded slot to binary.
module pixel_readout_receiver #(
    parameter int WIDTH                  = 3,
    parameter int HEIGHT                 = 3,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 3,
    parameter int BIT_DEPTH              = 10,
    localparam int NPIX                  = WIDTH * HEIGHT,
    localparam int IDX_W                 = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                                        SYSTEM_CLK,
    input  logic                                        RESET,
    input  logic                                        START,
    output logic                                        READ_RESET_OUT,
    output logic                                        READ_CLK_OUT,
    input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_IN,
    output logic [BIT_DEPTH-1:0]                        PIX_DATA,
    output logic [IDX_W-1:0]                            PIX_INDEX,
    output logic                                        PIX_LAST,
    output logic                                        PIX_VALID,
    input  logic                                        PIX_READY,
    output logic                                        BUSY,
    output logic                                        DONE
);

    localparam int OBW    = OUTPUT_BUS_PIXEL_WIDTH;
    localparam int BUS_W  = OBW * BIT_DEPTH;
    localparam int NWORDS = (NPIX + OBW - 1) / OBW;
    localparam int CNT_W  = $clog2(NPIX + 1);
    localparam int WRD_W  = $clog2(NWORDS + 1);
    localparam int SLOT_W = $clog2(OBW + 1);

    localparam logic [CNT_W-1:0]  NPIX_C   = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(NPIX - 1);
    localparam logic [WRD_W-1:0]  NWORDS_C = WRD_W'(NWORDS);
    localparam logic [SLOT_W-1:0] OBW_C    = SLOT_W'(OBW);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RRST   = 3'd1;
    localparam logic [2:0] S_CLK_HI = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    logic [2:0]        state;
    logic [BUS_W-1:0]  word_buf;
    logic [BUS_W-1:0]  buf_shifted;
    logic [BUS_W-1:0]  decoded_word;
    logic [SLOT_W-1:0] slot_ptr;
    logic [SLOT_W-1:0] slot_next;
    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  pix_next;
    logic [WRD_W-1:0]  word_cnt;
    logic              handshake;
    logic              word_end;

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
    function automatic logic [BIT_DEPTH-1:0] gray_to_bin(input logic [BIT_DEPTH-1:0] gray);
        logic [BIT_DEPTH-1:0] bin;
        bin[BIT_DEPTH-1] = gray[BIT_DEPTH-1];
        for (int i = BIT_DEPTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    for (genvar k = 0; k < OBW; k++) begin : g_gray
        assign decoded_word[k*BIT_DEPTH +: BIT_DEPTH] = gray_to_bin(DATA_IN[k*BIT_DEPTH +: BIT_DEPTH]);
    end
`else
    assign decoded_word = DATA_IN;
`endif

    // The buffer shifts down one slot per handshake, so the next pixel always sits in the low slot.
    always_comb begin
        handshake   = PIX_VALID && PIX_READY;
        pix_next    = (pix_cnt == NPIX_C) ? pix_cnt : pix_cnt + 1'b1;
        slot_next   = slot_ptr + 1'b1;
        word_end    = (slot_next == OBW_C) || (pix_next == NPIX_C);
        buf_shifted = word_buf >> BIT_DEPTH;
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (RESET) begin
            state          <= S_IDLE;
            READ_RESET_OUT <= 1'b0;
            READ_CLK_OUT   <= 1'b0;
            PIX_DATA       <= '0;
            PIX_INDEX      <= '0;
            PIX_LAST       <= 1'b0;
            PIX_VALID      <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            word_buf       <= '0;
            slot_ptr       <= '0;
            pix_cnt        <= '0;
            word_cnt       <= '0;
        end else begin
            READ_RESET_OUT <= 1'b0;
            READ_CLK_OUT   <= 1'b0;
            DONE           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state          <= S_RRST;
                        READ_RESET_OUT <= 1'b1;
                        BUSY           <= 1'b1;
                        word_cnt       <= '0;
                        pix_cnt        <= '0;
                    end
                end
                S_RRST: begin
                    state        <= S_CLK_HI;
                    READ_CLK_OUT <= 1'b1;
                end
                S_CLK_HI: begin
                    state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    state     <= S_DRAIN;
                    word_buf  <= decoded_word;
                    slot_ptr  <= '0;
                    PIX_DATA  <= decoded_word[BIT_DEPTH-1:0];
                    PIX_INDEX <= IDX_W'(pix_cnt);
                    PIX_LAST  <= (pix_cnt == LAST_C);
                    PIX_VALID <= 1'b1;
                    if (word_cnt != NWORDS_C) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (handshake) begin
                        slot_ptr <= slot_next;
                        pix_cnt  <= pix_next;
                        word_buf <= buf_shifted;
                        if (word_end) begin
                            PIX_VALID <= 1'b0;
                            PIX_DATA  <= '0;
                            PIX_INDEX <= '0;
                            PIX_LAST  <= 1'b0;
                            if ((pix_next == NPIX_C) || (word_cnt == NWORDS_C)) begin
                                state <= S_FIN;
                                DONE  <= 1'b1;
                                BUSY  <= 1'b0;
                            end else begin
                                state        <= S_CLK_HI;
                                READ_CLK_OUT <= 1'b1;
                            end
                        end else begin
                            PIX_DATA  <= buf_shifted[BIT_DEPTH-1:0];
                            PIX_INDEX <= IDX_W'(pix_next);
                            PIX_LAST  <= (pix_next == LAST_C);
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_readout_receiver.sv
// Bench for pixel_readout_receiver: models the pixel array and checks streamed frames against the expected pixel list.
// Covers the default 3x3 array and a 2x2 array with a partial last bus word.
module tb_pixel_readout_receiver;

    localparam int OBW      = 3;
    localparam int BD       = 10;
    localparam int NPIX     = 9;
    localparam int NWORDS   = 3;
    localparam int S_NPIX   = 4;
    localparam int S_NWORDS = 2;
    localparam int LIMIT    = 400;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              s_start;
    logic              pix_ready;
    logic [OBW*BD-1:0] data_in;
    logic [OBW*BD-1:0] s_data_in;
    logic              read_reset, read_clk, s_read_reset, s_read_clk;
    logic [BD-1:0]     pix_data, s_pix_data;
    logic [3:0]        pix_index;
    logic [1:0]        s_pix_index;
    logic              pix_last, pix_valid, busy, done;
    logic              s_pix_last, s_pix_valid, s_busy, s_done;

    logic [OBW*BD-1:0] frame_words [NWORDS];
    logic [OBW*BD-1:0] small_words [S_NWORDS];
    int arr_ptr     = 0;
    int s_arr_ptr   = 0;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pixel_readout_receiver dut (
        .SYSTEM_CLK     (clk),
        .RESET          (reset),
        .START          (start),
        .READ_RESET_OUT (read_reset),
        .READ_CLK_OUT   (read_clk),
        .DATA_IN        (data_in),
        .PIX_DATA       (pix_data),
        .PIX_INDEX      (pix_index),
        .PIX_LAST       (pix_last),
        .PIX_VALID      (pix_valid),
        .PIX_READY      (pix_ready),
        .BUSY           (busy),
        .DONE           (done)
    );

    pixel_readout_receiver #(.WIDTH(2), .HEIGHT(2)) dut_small (
        .SYSTEM_CLK     (clk),
        .RESET          (reset),
        .START          (s_start),
        .READ_RESET_OUT (s_read_reset),
        .READ_CLK_OUT   (s_read_clk),
        .DATA_IN        (s_data_in),
        .PIX_DATA       (s_pix_data),
        .PIX_INDEX      (s_pix_index),
        .PIX_LAST       (s_pix_last),
        .PIX_VALID      (s_pix_valid),
        .PIX_READY      (1'b1),
        .BUSY           (s_busy),
        .DONE           (s_done)
    );

    // Pixel array model: READ_RESET rewinds the word pointer, each READ_CLK rising edge presents the next word.
    always @(posedge read_reset) arr_ptr = 0;
    always @(posedge read_clk) begin
        data_in = (arr_ptr < NWORDS) ? frame_words[arr_ptr] : '1;
        arr_ptr++;
    end
    always @(posedge s_read_reset) s_arr_ptr = 0;
    always @(posedge s_read_clk) begin
        s_data_in = (s_arr_ptr < S_NWORDS) ? small_words[s_arr_ptr] : '1;
        s_arr_ptr++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Expected pixel value of one slot; Gray decode is the prefix XOR of the higher code bits.
    function automatic logic [BD-1:0] expSlot(input logic [OBW*BD-1:0] word, input int slot);
        logic [OBW*BD-1:0] shifted;
        logic [BD-1:0]     value;
        shifted = word >> (slot * BD);
        value   = shifted[BD-1:0];
`ifdef PIXEL_READOUT_GRAY_DECODE_EN
        begin : gray_blk
            logic [BD-1:0] gray;
            gray  = value;
            value = '0;
            for (int s = 0; s < BD; s++) value = value ^ (gray >> s);
        end
`endif
        return value;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " ctrl outs"}, 32'({read_reset, read_clk, pix_last, pix_valid, busy, done}), 32'd0);
        checkOutput({tag, " pix_data"}, 32'(pix_data), 32'd0);
        checkOutput({tag, " pix_index"}, 32'(pix_index), 32'd0);
    endtask

    task automatic applyStimulus(input string name, input int ready_mode, input bit repulse, input int abort_idx);
        int            got, clk_pulses, rrst_pulses, busy_cycles, last_hs, done_cyc, stall_hold, extra;
        bit            prev_stall, aborted;
        logic [BD-1:0] prev_data;
        logic [3:0]    prev_index;
        got = 0; clk_pulses = 0; rrst_pulses = 0; busy_cycles = 0;
        last_hs = -10; done_cyc = 0; stall_hold = 0; extra = 0;
        prev_stall = 1'b0; aborted = 1'b0; prev_data = '0; prev_index = '0;

        @(negedge clk);
        start     = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start = 1'b0;
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: begin
                    if (pix_valid && pix_index == 4'd4 && stall_hold < 3) begin
                        pix_ready = 1'b0;
                        stall_hold++;
                    end else begin
                        pix_ready = cyc[0];
                    end
                end
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase

            if (prev_stall) begin
                checkOutput({name, " stall data"}, 32'(pix_data), 32'(prev_data));
                checkOutput({name, " stall index"}, 32'(pix_index), 32'(prev_index));
            end
            if (read_reset) begin
                rrst_pulses++;
                checkOutput({name, " read_reset cycle"}, cyc, 32'd1);
            end
            if (read_clk) begin
                clk_pulses++;
                checkOutput({name, " read_clk after drain"}, got, (clk_pulses - 1) * OBW);
                checkOutput({name, " read_clk with valid"}, 32'(pix_valid), 32'd0);
            end
            if (!pix_valid) checkOutput({name, " last without valid"}, 32'(pix_last), 32'd0);
            if (pix_valid && pix_ready) begin
                if (got < NPIX) begin
                    checkOutput({name, " pix_data"}, 32'(pix_data), 32'(expSlot(frame_words[got / OBW], got % OBW)));
                    checkOutput({name, " pix_index"}, 32'(pix_index), got);
                    checkOutput({name, " pix_last"}, 32'(pix_last), 32'(got == NPIX - 1));
                end else begin
                    checkOutput({name, " extra pixel"}, got, NPIX - 1);
                end
                got++;
                last_hs = cyc;
            end
            if (busy) busy_cycles++;
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_index = pix_index;

            if (abort_idx >= 0 && pix_valid && 32'(pix_index) == abort_idx) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                checkIdleOutputs({name, " mid-frame reset"});
                @(negedge clk);
                checkIdleOutputs({name, " idle after reset"});
                aborted = 1'b1;
                break;
            end
            if (done) begin
                done_cyc = cyc;
                checkOutput({name, " done after last handshake"}, cyc, last_hs + 1);
                checkOutput({name, " busy at done"}, 32'(busy), 32'd0);
                start = repulse;
                break;
            end
            if (repulse && (cyc == 3 || cyc == 8)) start = 1'b1;
        end

        if (abort_idx >= 0) begin
            checkOutput({name, " abort point reached"}, 32'(aborted), 32'd1);
        end
        if (!aborted) begin
            checkOutput({name, " done seen"}, 32'(done_cyc != 0), 32'd1);
            checkOutput({name, " pixel count"}, got, NPIX);
            checkOutput({name, " read_clk pulses"}, clk_pulses, NWORDS);
            checkOutput({name, " read_reset pulses"}, rrst_pulses, 32'd1);
            checkOutput({name, " busy span"}, busy_cycles, done_cyc - 1);
            if (ready_mode == 0) checkOutput({name, " frame cycles"}, done_cyc, 2 + 2 * NWORDS + NPIX);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (read_reset || busy) extra++;
            end
            checkOutput({name, " no restart after done"}, extra, 32'd0);
        end
    endtask

    task automatic runSmall();
        int got, pulses, done_cyc;
        got = 0; pulses = 0; done_cyc = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (s_read_clk) pulses++;
            if (s_pix_valid) begin
                if (got < S_NPIX) begin
                    checkOutput("small pix_data", 32'(s_pix_data), 32'(expSlot(small_words[got / OBW], got % OBW)));
                    checkOutput("small pix_index", 32'(s_pix_index), got);
                    checkOutput("small pix_last", 32'(s_pix_last), 32'(got == S_NPIX - 1));
                end
                got++;
            end
            if (s_done) begin
                done_cyc = cyc;
                break;
            end
        end
        checkOutput("small pixel count", got, S_NPIX);
        checkOutput("small read_clk pulses", pulses, S_NWORDS);
        checkOutput("small frame cycles", done_cyc, 2 + 2 * S_NWORDS + S_NPIX);
    endtask

    task automatic randomWords();
        for (int i = 0; i < NWORDS; i++) frame_words[i] = (OBW*BD)'($urandom);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        s_start   = 1'b0;
        pix_ready = 1'b0;
        data_in   = '0;
        s_data_in = '0;
        frame_words[0] = 30'h00300801;
        frame_words[1] = 30'h01001405;
        frame_words[2] = 30'h01C02007;
        small_words[0] = {10'h0C3, 10'h0B2, 10'h0A1};
        small_words[1] = {10'h3E7, 10'h155, 10'h0D4};

        repeat (3) @(negedge clk);
        checkIdleOutputs("reset state");
        checkOutput("small reset busy", 32'({s_busy, s_pix_valid, s_done}), 32'd0);
        reset = 1'b0;

        applyStimulus("directed", 0, 1'b0, -1);

        frame_words[0] = {10'h155, 10'h001, 10'h3FF};
        frame_words[1] = {10'h200, 10'h3FF, 10'h001};
        frame_words[2] = {10'h0F0, 10'h2AA, 10'h3FF};
        applyStimulus("gray slots", 0, 1'b0, -1);

        randomWords();
        applyStimulus("toggle ready", 1, 1'b0, -1);
        randomWords();
        applyStimulus("start repulse", 2, 1'b1, -1);
        randomWords();
        applyStimulus("abort", 2, 1'b0, 5);
        randomWords();
        applyStimulus("after abort", 0, 1'b0, -1);
        randomWords();
        applyStimulus("random ready", 2, 1'b0, -1);

        runSmall();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
